// File: rtl/arduboy_top.sv
// rtl/arduboy_top.sv - arduFPGA Arduboy board I/O controller (UART command port, OLED SPI, LED, buzzer, buttons)
//
// Purpose: a host sends two-byte UART commands (opcode, argument) to push OLED
// command/data bytes over SPI, set the RGB LED, set a buzzer tone or read the
// debounced buttons. Unused chip-selects are held inactive.
//
// Ports:
//   clk, rst_n                  system clock, async active-low reset
//   RGB0..RGB2                  LED channels, active-low
//   BUZ_L, BUZ_R, BUZ_G         buzzer push-pull pair and reference (0)
//   OLED_DC/SS/RST, SCK, MOSI   OLED SPI master and reset
//   MISO                        SPI master input
//   BTN_*                       buttons, active-low
//   BTN_INTERRUPT               active-low button-change flag
//   DES_SS, uSD_SS, APP_SS      chip-selects, held 1
//   uSD_CD, VS_DREQ             synchronized, otherwise unused
//   VS_RST, VS_xCS, VS_xDCS     VS1053 reset and selects (selects held 1)
//   UART_TX, UART_RX            8N1 serial port
//
// Optional feature macro: SPI_ECHO_EN - MISO byte of each SPI transfer is sent on UART_TX.

module arduboy_top #(
    parameter int BAUD_DIV        = 868,
    parameter int SPI_DIV         = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int RST_CYCLES      = 1000,
    parameter int TONE_SCALE      = 256
) (
    input  logic clk,
    input  logic rst_n,
    output logic RGB0,
    output logic RGB1,
    output logic RGB2,
    output logic BUZ_L,
    output logic BUZ_R,
    output logic BUZ_G,
    output logic OLED_DC,
    output logic OLED_SS,
    output logic OLED_RST,
    output logic SCK,
    output logic MOSI,
    input  logic MISO,
    input  logic BTN_RIGHT,
    input  logic BTN_LEFT,
    input  logic BTN_UP,
    input  logic BTN_DN,
    input  logic BTN_BACK,
    input  logic BTN_OK,
    output logic BTN_INTERRUPT,
    output logic DES_SS,
    output logic uSD_SS,
    output logic APP_SS,
    input  logic uSD_CD,
    output logic VS_RST,
    output logic VS_xCS,
    output logic VS_xDCS,
    input  logic VS_DREQ,
    output logic UART_TX,
    input  logic UART_RX
);
    localparam int BW = $clog2(BAUD_DIV + 1);
    localparam int SW = $clog2(SPI_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = 8 + $clog2(TONE_SCALE + 1);

    localparam logic [2:0] RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_STOP = 3'd3, RX_BREAK = 3'd4;
    localparam logic [1:0] CMD_IDLE = 2'd0, CMD_ARG = 2'd1, CMD_EXEC = 2'd2;
    localparam logic [2:0] SPI_IDLE = 3'd0, SPI_SEL = 3'd1, SPI_LOW = 3'd2, SPI_HIGH = 3'd3,
                           SPI_END = 3'd4, SPI_GAP = 3'd5;

    // Reset: async assert, release synchronized to clk.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Power-up reset hold. The two synchronizer clocks count toward RST_CYCLES.
    logic [RW-1:0] r_rst_cnt;
    logic          r_rst_done;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rst_cnt  <= '0;
            r_rst_done <= 1'b0;
        end else if (!r_rst_done) begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
            if (r_rst_cnt == RW'(RST_CYCLES - 3)) r_rst_done <= 1'b1;
        end
    end

    // Input synchronizers: {VS_DREQ, uSD_CD, MISO, UART_RX, OK, BACK, DN, UP, LEFT, RIGHT}
    logic [9:0] r_in_s1, r_in_s2;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_in_s1 <= 10'h07F;
            r_in_s2 <= 10'h07F;
        end else begin
            r_in_s1 <= {VS_DREQ, uSD_CD, MISO, UART_RX, BTN_OK, BTN_BACK, BTN_DN, BTN_UP, BTN_LEFT, BTN_RIGHT};
            r_in_s2 <= r_in_s1;
        end
    end
    logic [5:0] w_btn_pressed;
    logic       w_rx;
    assign w_btn_pressed = ~r_in_s2[5:0];
    assign w_rx          = r_in_s2[6];

    // Button debounce, one counter per button.
    logic [5:0]         r_btn_state;
    logic [5:0][DW-1:0] r_db_cnt;
    logic [5:0]         w_db_hit;
    always_comb begin
        w_db_hit = '0;
        for (int i = 0; i < 6; i++)
            w_db_hit[i] = (w_btn_pressed[i] != r_btn_state[i]) && (r_db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1));
    end
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_btn_state <= '0;
            r_db_cnt    <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_btn_pressed[i] == r_btn_state[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_db_hit[i]) begin
                    r_btn_state[i] <= w_btn_pressed[i];
                    r_db_cnt[i]    <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // UART receiver. After a bad stop bit, wait for the line to go high so the
    // low stop bit is not mistaken for a new start bit.
    logic [2:0]    r_rx_state;
    logic [BW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_rx_valid;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_rx_state)
                RX_IDLE: if (!w_rx) begin
                    r_rx_state <= RX_START;
                    r_rx_cnt   <= '0;
                end
                RX_START: if (r_rx_cnt == BW'(BAUD_DIV / 2 - 1)) begin
                    r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
                    r_rx_cnt   <= '0;
                    r_rx_bit   <= '0;
                end else r_rx_cnt <= r_rx_cnt + 1'b1;
                RX_DATA: if (r_rx_cnt == BW'(BAUD_DIV - 1)) begin
                    r_rx_cnt   <= '0;
                    r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                    else                  r_rx_bit   <= r_rx_bit + 1'b1;
                end else r_rx_cnt <= r_rx_cnt + 1'b1;
                RX_STOP: if (r_rx_cnt == BW'(BAUD_DIV - 1)) begin
                    r_rx_cnt   <= '0;
                    r_rx_valid <= w_rx;
                    r_rx_state <= w_rx ? RX_IDLE : RX_BREAK;
                end else r_rx_cnt <= r_rx_cnt + 1'b1;
                RX_BREAK: if (w_rx) r_rx_state <= RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Command FSM.
    logic [1:0] r_cmd_state;
    logic [7:0] r_opcode, r_arg;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cmd_state <= CMD_IDLE;
            r_opcode    <= '0;
            r_arg       <= '0;
        end else begin
            case (r_cmd_state)
                CMD_IDLE: if (r_rx_valid) begin r_opcode <= r_rx_shift; r_cmd_state <= CMD_ARG; end
                CMD_ARG:  if (r_rx_valid) begin r_arg    <= r_rx_shift; r_cmd_state <= CMD_EXEC; end
                default:  r_cmd_state <= CMD_IDLE;
            endcase
        end
    end

    logic [2:0] r_spi_state;
    logic       r_tx_busy;
    logic       w_spi_busy, w_spi_start, w_spi_dc, w_tx_reply, w_rgb_we, w_tone_we, w_spi_done;
    assign w_spi_busy = (r_spi_state != SPI_IDLE);
    assign w_spi_done = (r_spi_state == SPI_END);
    always_comb begin
        w_spi_start = 1'b0;
        w_spi_dc    = 1'b0;
        w_tx_reply  = 1'b0;
        w_rgb_we    = 1'b0;
        w_tone_we   = 1'b0;
        if (r_cmd_state == CMD_EXEC) begin
            case (r_opcode)
                8'h01:   w_spi_start = !w_spi_busy;
                8'h02:   begin w_spi_start = !w_spi_busy; w_spi_dc = 1'b1; end
                8'h03:   w_rgb_we   = 1'b1;
                8'h04:   w_tone_we  = 1'b1;
                8'h05:   w_tx_reply = !r_tx_busy;
                default: ;
            endcase
        end
    end

    // SPI master, mode 0, MSB first.
    logic [SW-1:0] r_spi_cnt;
    logic [2:0]    r_spi_bit;
    logic [7:0]    r_spi_tx;
    logic          r_oled_dc, r_oled_ss, r_sck, r_mosi;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_spi_state <= SPI_IDLE;
            r_spi_cnt   <= '0;
            r_spi_bit   <= '0;
            r_spi_tx    <= '0;
            r_oled_dc   <= 1'b0;
            r_oled_ss   <= 1'b1;
            r_sck       <= 1'b0;
            r_mosi      <= 1'b0;
        end else begin
            case (r_spi_state)
                SPI_IDLE: if (w_spi_start) begin
                    r_oled_dc   <= w_spi_dc;
                    r_spi_tx    <= r_arg;
                    r_spi_state <= SPI_SEL;
                end
                SPI_SEL: begin
                    r_oled_ss   <= 1'b0;
                    r_mosi      <= r_spi_tx[7];
                    r_spi_cnt   <= '0;
                    r_spi_bit   <= '0;
                    r_spi_state <= SPI_LOW;
                end
                SPI_LOW: if (r_spi_cnt == SW'(SPI_DIV - 1)) begin
                    r_sck       <= 1'b1;
                    r_spi_cnt   <= '0;
                    r_spi_state <= SPI_HIGH;
                end else r_spi_cnt <= r_spi_cnt + 1'b1;
                SPI_HIGH: if (r_spi_cnt == SW'(SPI_DIV - 1)) begin
                    r_sck     <= 1'b0;
                    r_spi_cnt <= '0;
                    if (r_spi_bit == 3'd7) begin
                        r_spi_state <= SPI_END;
                    end else begin
                        r_spi_bit   <= r_spi_bit + 1'b1;
                        r_mosi      <= r_spi_tx[6];
                        r_spi_tx    <= {r_spi_tx[6:0], 1'b0};
                        r_spi_state <= SPI_LOW;
                    end
                end else r_spi_cnt <= r_spi_cnt + 1'b1;
                SPI_END: begin
                    r_oled_ss   <= 1'b1;
                    r_mosi      <= 1'b0;
                    r_spi_cnt   <= '0;
                    r_spi_state <= SPI_GAP;
                end
                SPI_GAP: if (r_spi_cnt == SW'(SPI_DIV - 1)) r_spi_state <= SPI_IDLE;
                         else r_spi_cnt <= r_spi_cnt + 1'b1;
                default: r_spi_state <= SPI_IDLE;
            endcase
        end
    end

    logic w_unused;
`ifdef SPI_ECHO_EN
    // MISO is captured on the same clock SCK rises.
    logic [7:0] r_spi_rx;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_spi_rx <= '0;
        else if (r_spi_state == SPI_LOW && r_spi_cnt == SW'(SPI_DIV - 1))
            r_spi_rx <= {r_spi_rx[6:0], r_in_s2[7]};
    end
    assign w_unused = ^r_in_s2[9:8];
`else
    assign w_unused = ^{r_in_s2[9:7], w_spi_done};
`endif

    // UART transmitter. A button reply has priority over an SPI echo.
    logic       w_tx_load;
    logic [7:0] w_tx_data;
    always_comb begin
        w_tx_load = w_tx_reply;
        w_tx_data = {2'b00, r_btn_state};
`ifdef SPI_ECHO_EN
        if (!w_tx_reply && w_spi_done && !r_tx_busy) begin
            w_tx_load = 1'b1;
            w_tx_data = r_spi_rx;
        end
`endif
    end

    logic [9:0]    r_tx_shift;
    logic [BW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_nbit;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_tx_shift <= '1;
            r_tx_cnt   <= '0;
            r_tx_nbit  <= '0;
            r_tx_busy  <= 1'b0;
        end else if (w_tx_load) begin
            r_tx_shift <= {1'b1, w_tx_data, 1'b0};
            r_tx_cnt   <= '0;
            r_tx_nbit  <= '0;
            r_tx_busy  <= 1'b1;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == BW'(BAUD_DIV - 1)) begin
                r_tx_cnt   <= '0;
                r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                if (r_tx_nbit == 4'd9) r_tx_busy <= 1'b0;
                else                   r_tx_nbit <= r_tx_nbit + 1'b1;
            end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

    // Button-change flag; a change in the clearing clock wins.
    logic r_pending;
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n)        r_pending <= 1'b0;
        else if (|w_db_hit)  r_pending <= 1'b1;
        else if (w_tx_reply) r_pending <= 1'b0;
    end

    // RGB LED and buzzer.
    logic [2:0]    r_rgb;
    logic [7:0]    r_tone;
    logic [TW-1:0] r_buz_cnt;
    logic          r_buz_l;
    logic [TW-1:0] w_buz_lim;
    assign w_buz_lim = TW'(r_tone) * TW'(TONE_SCALE) - TW'(1);
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rgb     <= 3'b111;
            r_tone    <= '0;
            r_buz_cnt <= '0;
            r_buz_l   <= 1'b0;
        end else begin
            if (w_rgb_we) r_rgb <= ~r_arg[2:0];
            if (w_tone_we) begin
                r_tone    <= r_arg;
                r_buz_cnt <= '0;
                r_buz_l   <= 1'b0;
            end else if (r_tone == 8'd0) begin
                r_buz_cnt <= '0;
                r_buz_l   <= 1'b0;
            end else if (r_buz_cnt == w_buz_lim) begin
                r_buz_cnt <= '0;
                r_buz_l   <= ~r_buz_l;
            end else r_buz_cnt <= r_buz_cnt + 1'b1;
        end
    end

    assign RGB0          = r_rgb[0];
    assign RGB1          = r_rgb[1];
    assign RGB2          = r_rgb[2];
    assign BUZ_L         = r_buz_l;
    assign BUZ_R         = (r_tone != 8'd0) && !r_buz_l;
    assign BUZ_G         = 1'b0;
    assign OLED_DC       = r_oled_dc;
    assign OLED_SS       = r_oled_ss;
    assign OLED_RST      = r_rst_done;
    assign SCK           = r_sck;
    assign MOSI          = r_mosi;
    assign BTN_INTERRUPT = ~r_pending;
    assign DES_SS        = 1'b1;
    assign uSD_SS        = 1'b1;
    assign APP_SS        = 1'b1;
    assign VS_RST        = r_rst_done;
    assign VS_xCS        = 1'b1;
    assign VS_xDCS       = 1'b1;
    assign UART_TX       = r_tx_shift[0];
endmodule

// File: tb/tb_arduboy_top.sv
// tb/tb_arduboy_top.sv - directed self-checking bench for arduboy_top
module tb_arduboy_top;
    localparam int BAUD = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic RGB0, RGB1, RGB2, BUZ_L, BUZ_R, BUZ_G;
    logic OLED_DC, OLED_SS, OLED_RST, SCK, MOSI, MISO;
    logic BTN_RIGHT, BTN_LEFT, BTN_UP, BTN_DN, BTN_BACK, BTN_OK, BTN_INTERRUPT;
    logic DES_SS, uSD_SS, APP_SS, uSD_CD, VS_RST, VS_xCS, VS_xDCS, VS_DREQ;
    logic UART_TX, UART_RX;

    always #5 clk = ~clk;

    arduboy_top #(
        .BAUD_DIV(BAUD), .SPI_DIV(2), .DEBOUNCE_CYCLES(10), .RST_CYCLES(20), .TONE_SCALE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .RGB0(RGB0), .RGB1(RGB1), .RGB2(RGB2),
        .BUZ_L(BUZ_L), .BUZ_R(BUZ_R), .BUZ_G(BUZ_G),
        .OLED_DC(OLED_DC), .OLED_SS(OLED_SS), .OLED_RST(OLED_RST),
        .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .BTN_RIGHT(BTN_RIGHT), .BTN_LEFT(BTN_LEFT), .BTN_UP(BTN_UP), .BTN_DN(BTN_DN),
        .BTN_BACK(BTN_BACK), .BTN_OK(BTN_OK), .BTN_INTERRUPT(BTN_INTERRUPT),
        .DES_SS(DES_SS), .uSD_SS(uSD_SS), .APP_SS(APP_SS), .uSD_CD(uSD_CD),
        .VS_RST(VS_RST), .VS_xCS(VS_xCS), .VS_xDCS(VS_xDCS), .VS_DREQ(VS_DREQ),
        .UART_TX(UART_TX), .UART_RX(UART_RX)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic uart_send(input logic [7:0] d, input logic stop);
        @(negedge clk);
        UART_RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int b = 0; b < 8; b++) begin
            UART_RX = d[b];
            repeat (BAUD) @(negedge clk);
        end
        UART_RX = stop;
        repeat (BAUD) @(negedge clk);
        UART_RX = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [7:0] arg);
        uart_send(op, 1'b1);
        uart_send(arg, 1'b1);
    endtask

    task automatic uart_recv(input int limit, output logic [7:0] d, output logic ok);
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!UART_TX) begin ok = 1'b1; break; end
        end
        if (ok) begin
            repeat (BAUD / 2) @(negedge clk);
            for (int b = 0; b < 8; b++) begin
                repeat (BAUD) @(negedge clk);
                d[b] = UART_TX;
            end
            repeat (BAUD) @(negedge clk);
            if (!UART_TX) ok = 1'b0;
        end
    endtask

    // SPI observation results
    logic [7:0] spi_bits;
    int         spi_rises, spi_first, spi_last, spi_hi;
    logic       spi_seen, spi_dc;

    task automatic spi_mon();
        logic prev;
        spi_bits = 8'h00; spi_rises = 0; spi_first = 0; spi_last = 0; spi_hi = 0;
        spi_seen = 1'b0; spi_dc = 1'b0; prev = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (!OLED_SS) begin spi_seen = 1'b1; spi_dc = OLED_DC; break; end
        end
        if (spi_seen) begin
            for (int c = 0; c < 200; c++) begin
                if (SCK && !prev) begin
                    spi_bits = {spi_bits[6:0], MOSI};
                    if (spi_rises == 0) spi_first = c;
                    spi_last = c;
                    spi_rises++;
                end
                if (SCK) spi_hi++;
                prev = SCK;
                @(negedge clk);
                if (OLED_SS) break;
            end
        end
    endtask

    logic [7:0] rx_d;
    logic       rx_ok;
    int         bt0, bt1, bt2, bn;
    logic       bprev;

    initial begin
        rst_n = 1'b1; UART_RX = 1'b1; MISO = 1'b1; uSD_CD = 1'b0; VS_DREQ = 1'b0;
        BTN_RIGHT = 1'b1; BTN_LEFT = 1'b1; BTN_UP = 1'b1; BTN_DN = 1'b1; BTN_BACK = 1'b1; BTN_OK = 1'b1;
        #2 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_outs",
              {RGB0, RGB1, RGB2, BUZ_L, BUZ_R, BUZ_G, OLED_DC, OLED_SS, OLED_RST, SCK, MOSI,
               BTN_INTERRUPT, UART_TX, VS_RST, DES_SS, uSD_SS, APP_SS, VS_xCS, VS_xDCS},
              {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

        // Power-up reset: rises on the 20th clock after release.
        rst_n = 1'b1;
        repeat (19) @(posedge clk);
        #1;
        check("oled_rst_19", OLED_RST, 1'b0);
        check("vs_rst_19", VS_RST, 1'b0);
        @(posedge clk);
        #1;
        check("oled_rst_20", OLED_RST, 1'b1);
        check("vs_rst_20", VS_RST, 1'b1);
        repeat (10) @(negedge clk);

        // RGB set
        send_cmd(8'h03, 8'h05);
        check("rgb_a", {RGB2, RGB1, RGB0}, 3'b010);
        // Bad stop bits: all three bytes discarded
        uart_send(8'h01, 1'b0);
        uart_send(8'h02, 1'b0);
        uart_send(8'h09, 1'b0);
        repeat (20) @(negedge clk);
        check("rgb_badstop", {RGB2, RGB1, RGB0}, 3'b010);
        check("ss_badstop", OLED_SS, 1'b1);
        send_cmd(8'h03, 8'h02);
        check("rgb_b", {RGB2, RGB1, RGB0}, 3'b101);
        // Unknown opcode consumes its argument
        send_cmd(8'h07, 8'h55);
        check("rgb_unknown", {RGB2, RGB1, RGB0}, 3'b101);
        send_cmd(8'h03, 8'h07);
        check("rgb_c", {RGB2, RGB1, RGB0}, 3'b000);

        // SPI data byte
        fork
            send_cmd(8'h02, 8'hA5);
            spi_mon();
        join
        check("spi_seen", spi_seen, 1'b1);
        check("spi_dc", spi_dc, 1'b1);
        check("spi_bits", spi_bits, 8'hA5);
        check("spi_rises", spi_rises, 8);
        check("spi_span", spi_last - spi_first, 28);
        check("spi_hi", spi_hi, 16);
        check("spi_ss_end", OLED_SS, 1'b1);
        check("spi_sck_end", SCK, 1'b0);
        check("spi_dc_hold", OLED_DC, 1'b1);
        repeat (200) @(negedge clk);

        // Buttons
        BTN_UP = 1'b0;
        repeat (5) @(negedge clk);
        check("int_early", BTN_INTERRUPT, 1'b1);
        repeat (45) @(negedge clk);
        check("int_up", BTN_INTERRUPT, 1'b0);
        fork
            send_cmd(8'h05, 8'h00);
            uart_recv(1000, rx_d, rx_ok);
        join
        check("reply1_ok", rx_ok, 1'b1);
        check("reply1", rx_d, 8'h04);
        check("int_clr", BTN_INTERRUPT, 1'b1);
        BTN_OK = 1'b0;
        repeat (5) @(negedge clk);
        BTN_OK = 1'b1;
        repeat (30) @(negedge clk);
        check("int_glitch", BTN_INTERRUPT, 1'b1);
        fork
            send_cmd(8'h05, 8'h00);
            uart_recv(1000, rx_d, rx_ok);
        join
        check("reply2", rx_d, 8'h04);
        BTN_UP = 1'b1;
        repeat (50) @(negedge clk);
        check("int_release", BTN_INTERRUPT, 1'b0);
        fork
            send_cmd(8'h05, 8'h00);
            uart_recv(1000, rx_d, rx_ok);
        join
        check("reply3", rx_d, 8'h00);
        check("int_clr2", BTN_INTERRUPT, 1'b1);

        // Buzzer
        send_cmd(8'h04, 8'h02);
        bn = 0; bt0 = 0; bt1 = 0; bt2 = 0; bprev = BUZ_L;
        for (int c = 0; c < 200 && bn < 3; c++) begin
            @(negedge clk);
            if (BUZ_L != bprev) begin
                if (bn == 0) bt0 = c;
                else if (bn == 1) bt1 = c;
                else bt2 = c;
                bn++;
                bprev = BUZ_L;
                check("buz_r_inv", BUZ_R, !BUZ_L);
            end
        end
        check("buz_edges", bn, 3);
        check("buz_gap1", bt1 - bt0, 8);
        check("buz_gap2", bt2 - bt1, 8);
        send_cmd(8'h04, 8'h00);
        repeat (20) @(negedge clk);
        check("buz_off", {BUZ_L, BUZ_R, BUZ_G}, 3'b000);

        // MISO echo of a command byte
        fork
            send_cmd(8'h01, 8'h00);
            uart_recv(1000, rx_d, rx_ok);
        join
`ifdef SPI_ECHO_EN
        check("echo_ok", rx_ok, 1'b1);
        check("echo", rx_d, 8'hFF);
`else
        check("no_echo", rx_ok, 1'b0);
`endif
        check("dc_cmd", OLED_DC, 1'b0);
        check("ss_idle", OLED_SS, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
